// File: rtl/gcd_seq_pkg.sv
// Shared types and defaults for the GCD operand sequencer.
package gcd_seq_pkg;

  localparam int GCD_WIDTH_DEFAULT = 8;
  localparam int GCD_GAP_DEFAULT   = 15;
  localparam int GCD_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRST,
    S_GAP1,
    S_LDX,
    S_GAP2,
    S_LDY,
    S_WAIT,
    S_DONE
  } gcd_seq_state_t;

endpackage

// File: rtl/gcd_seq_fifo.sv
// Operand-pair FIFO: DEPTH entries of {X, Y}. DEPTH must be a power of two
// so the pointers wrap by natural overflow. A push is refused while full,
// even if a pop happens in the same cycle.
module gcd_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 push,
  input  logic [2*WIDTH-1:0]   push_data,
  input  logic                 pop,
  output logic [2*WIDTH-1:0]   head,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge Clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Feeds queued operand pairs to the GCD Processor: reset it, enter X then Y
// with GAP idle cycles before each Enter, wait for Halt, then offer the
// captured Output on a valid/ready result port.
// Optional build macro GCD_SEQ_ZERO_CHECK_EN: pairs with a zero operand are
// answered directly with ResError=1, ResData=0 without touching the processor.
module gcd_operand_sequencer
  import gcd_seq_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEFAULT,
  parameter int DEPTH = GCD_DEPTH_DEFAULT,
  parameter int GAP   = GCD_GAP_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InX,
  input  logic [WIDTH-1:0] InY,
  output logic             ProcReset,
  output logic             Enter,
  output logic [WIDTH-1:0] ProcInput,
  input  logic             Halt,
  input  logic [WIDTH-1:0] ProcOutput,
  output logic             ResValid,
  input  logic             ResReady,
  output logic [WIDTH-1:0] ResData,
  output logic             ResError,
  output logic             Busy
);

  localparam int CNT_W = $clog2(GAP + 1);

  gcd_seq_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   x_q, y_q;
  logic [WIDTH-1:0]   res_data_q;
  logic               fifo_full, fifo_empty, pop;
  logic [2*WIDTH-1:0] fifo_head;
  logic               gap_done;
  logic               zero_head;

  gcd_seq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (InValid),
    .push_data ({InX, InY}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign InReady  = !fifo_full;
  assign gap_done = (cnt_q == CNT_W'(GAP - 1));
  assign ResData  = res_data_q;

`ifdef GCD_SEQ_ZERO_CHECK_EN
  logic res_err_q;
  assign zero_head = (fifo_head[2*WIDTH-1:WIDTH] == '0) || (fifo_head[WIDTH-1:0] == '0);
  assign ResError  = res_err_q;

  // Error flag: set for short-circuited zero jobs, cleared by real results.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      res_err_q <= 1'b0;
    end else if (state_q == S_WAIT && Halt) begin
      res_err_q <= 1'b0;
    end else if (pop && zero_head) begin
      res_err_q <= 1'b1;
    end
  end
`else
  assign zero_head = 1'b0;
  assign ResError  = 1'b0;
`endif

  // Next-state, FIFO pop and processor-facing outputs.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    Enter     = 1'b0;
    ProcInput = '0;
    ProcReset = Reset;
    ResValid  = 1'b0;
    Busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = zero_head ? S_DONE : S_PRST;
        end
      end
      S_PRST: begin
        ProcReset = 1'b1;
        state_d   = S_GAP1;
      end
      S_GAP1: if (gap_done) state_d = S_LDX;
      S_LDX: begin
        Enter     = 1'b1;
        ProcInput = x_q;
        state_d   = S_GAP2;
      end
      S_GAP2: if (gap_done) state_d = S_LDY;
      S_LDY: begin
        Enter     = 1'b1;
        ProcInput = y_q;
        state_d   = S_WAIT;
      end
      S_WAIT: if (Halt) state_d = S_DONE;
      S_DONE: begin
        ResValid = 1'b1;
        if (ResReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Gap counter: runs only in the two gap states, restarts from zero each time.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if ((state_q == S_GAP1 || state_q == S_GAP2) && !gap_done) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Operand capture on pop.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pop) begin
      x_q <= fifo_head[2*WIDTH-1:WIDTH];
      y_q <= fifo_head[WIDTH-1:0];
    end
  end

  // Result capture: processor output on Halt, or zero for a rejected pair.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      res_data_q <= '0;
    end else if (state_q == S_WAIT && Halt) begin
      res_data_q <= ProcOutput;
    end else if (pop && zero_head) begin
      res_data_q <= '0;
    end
  end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Bench for gcd_operand_sequencer with a behavioural GCD processor model and
// a result scoreboard.
module tb_gcd_operand_sequencer;
  import gcd_seq_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 15;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InX, InY;
  logic             ProcReset;
  logic             Enter;
  logic [WIDTH-1:0] ProcInput;
  logic             Halt = 1'b0;
  logic [WIDTH-1:0] ProcOutput = '0;
  logic             ResValid;
  logic             ResReady;
  logic [WIDTH-1:0] ResData;
  logic             ResError;
  logic             Busy;

  always #5 Clock = ~Clock;

  gcd_operand_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(GAP)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .InX        (InX),
    .InY        (InY),
    .ProcReset  (ProcReset),
    .Enter      (Enter),
    .ProcInput  (ProcInput),
    .Halt       (Halt),
    .ProcOutput (ProcOutput),
    .ResValid   (ResValid),
    .ResReady   (ResReady),
    .ResData    (ResData),
    .ResError   (ResError),
    .Busy       (Busy)
  );

  typedef struct packed { logic [WIDTH-1:0] x; logic [WIDTH-1:0] y; } pair_t;
  typedef struct packed { logic [WIDTH-1:0] d; logic e; } res_t;

  pair_t opq[$];
  res_t  sbq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int prst_cyc = 0;
  int enter_idx = 0;
  int enter_count = 0;
  int prst_count = 0;
  int res_count = 0;
  bit waiting = 0;
  bit halt_pending = 0;
  bit halt_block = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in);
    logic [WIDTH-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural GCD processor: captures two Enter values, halts a few cycles later.
  logic [WIDTH-1:0] px = '0, py = '0;
  int penters = 0;
  int plat = 0;
  always @(posedge Clock) begin
    if (ProcReset) begin
      Halt       <= 1'b0;
      ProcOutput <= '0;
      penters    <= 0;
      plat       <= 0;
    end else if (Enter) begin
      if (penters == 0) px <= ProcInput;
      else              py <= ProcInput;
      penters <= penters + 1;
      plat    <= 3 + (cyc % 4);
    end else if (penters == 2 && !Halt && !halt_block) begin
      if (plat > 0) plat <= plat - 1;
      else begin
        Halt       <= 1'b1;
        ProcOutput <= gcd_ref(px, py);
      end
    end
  end

  always @(posedge Clock) cyc <= cyc + 1;

  // Monitor: Enter timing/values, result latency, scoreboard pops.
  always @(negedge Clock) begin
    if (Reset) begin
      waiting      = 0;
      halt_pending = 0;
      enter_idx    = 0;
    end else begin
      if (!Enter) chk("procinput_idle", ProcInput, 0);
      if (halt_pending) begin
        chk("resvalid_after_halt", ResValid, 1);
        halt_pending = 0;
      end else if (waiting) begin
        chk("resvalid_before_halt", ResValid, 0);
        if (Halt) begin
          halt_pending = 1;
          waiting      = 0;
        end
      end
      if (ProcReset) begin
        prst_cyc  = cyc;
        enter_idx = 0;
        prst_count++;
      end
      if (Enter) begin
        enter_count++;
        if (opq.size() == 0) begin
          chk("enter_unexpected", 1, 0);
        end else if (enter_idx == 0) begin
          chk("enter_x_cycle", cyc - prst_cyc, GAP + 1);
          chk("enter_x_data", ProcInput, opq[0].x);
          enter_idx = 1;
        end else begin
          chk("enter_y_cycle", cyc - prst_cyc, 2 * GAP + 2);
          chk("enter_y_data", ProcInput, opq[0].y);
          void'(opq.pop_front());
          enter_idx = 0;
          waiting   = 1;
        end
      end
      if (ResValid && ResReady) begin
        res_count++;
        if (sbq.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("res_data", ResData, sbq[0].d);
          chk("res_error", ResError, sbq[0].e);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic push_pair(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    bit ok = 0;
    bit zero_job = 0;
    InValid = 1'b1;
    InX     = x;
    InY     = y;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge Clock);
      if (InReady) begin
        @(posedge Clock);
        ok = 1;
      end
    end
    if (!ok) chk("push_timeout", 0, 1);
    else begin
`ifdef GCD_SEQ_ZERO_CHECK_EN
      zero_job = (x == 0) || (y == 0);
`endif
      if (zero_job) sbq.push_back('{d: '0, e: 1'b1});
      else begin
        opq.push_back('{x: x, y: y});
        sbq.push_back('{d: gcd_ref(x, y), e: 1'b0});
      end
    end
    #1;
    InValid = 1'b0;
  endtask

  task automatic wait_res(input int target, input int budget);
    for (int i = 0; i < budget && res_count < target; i++) @(posedge Clock);
    #1;
    chk("result_count", res_count, target);
  endtask

  int r0, p0, e0;
  logic [WIDTH-1:0] d0;

  initial begin
    Reset    = 1'b1;
    InValid  = 1'b0;
    InX      = '0;
    InY      = '0;
    ResReady = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_procreset", ProcReset, 1);
    chk("rst_enter", Enter, 0);
    chk("rst_procinput", ProcInput, 0);
    chk("rst_resvalid", ResValid, 0);
    chk("rst_resdata", ResData, 0);
    chk("rst_reserror", ResError, 0);
    chk("rst_busy", Busy, 0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    #1;
    chk("rel_inready", InReady, 1);
    chk("rel_procreset", ProcReset, 0);

    // Basic job
    ResReady = 1'b1;
    r0 = res_count;
    push_pair(8'd12, 8'd18);
    wait_res(r0 + 1, 300);

    // Back-to-back jobs
    r0 = res_count;
    p0 = prst_count;
    push_pair(8'd7, 8'd5);
    push_pair(8'd100, 8'd75);
    push_pair(8'd81, 8'd27);
    wait_res(r0 + 3, 800);
    chk("prst_per_job", prst_count - p0, 3);

    // FIFO full while stalled in DONE, plus result backpressure
    ResReady = 1'b0;
    r0 = res_count;
    push_pair(8'd9, 8'd6);
    for (int i = 0; i < 300 && !ResValid; i++) @(posedge Clock);
    #1;
    chk("stall_done", ResValid, 1);
    push_pair(8'd20, 8'd8);
    push_pair(8'd35, 8'd21);
    push_pair(8'd64, 8'd48);
    chk("inready_3", InReady, 1);
    push_pair(8'd17, 8'd51);
    chk("inready_full", InReady, 0);
    InValid = 1'b1;
    InX = 8'd99;
    InY = 8'd33;
    e0 = enter_count;
    d0 = ResData;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      chk("bp_resvalid", ResValid, 1);
      chk("bp_resdata", ResData, d0);
      chk("bp_inready", InReady, 0);
    end
    chk("bp_no_enter", enter_count - e0, 0);
    @(posedge Clock);
    #1;
    InValid  = 1'b0;
    ResReady = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    chk("inready_before_pop", InReady, 0);
    @(negedge Clock);
    chk("inready_after_pop", InReady, 1);
    wait_res(r0 + 5, 1500);
    repeat (40) @(posedge Clock);
    #1;
    chk("fifo5_extra_result", res_count, r0 + 5);
    chk("fifo5_idle", Busy, 0);
    chk("sb_drained", sbq.size(), 0);

    // Zero operand
    r0 = res_count;
    e0 = enter_count;
    push_pair(8'd0, 8'd9);
    wait_res(r0 + 1, 300);
`ifdef GCD_SEQ_ZERO_CHECK_EN
    chk("zero_enters", enter_count - e0, 0);
`else
    chk("zero_enters", enter_count - e0, 2);
`endif

    // Reset during WAIT with two pairs queued
    halt_block = 1;
    e0 = enter_count;
    push_pair(8'd48, 8'd36);
    for (int i = 0; i < 300 && enter_count < e0 + 2; i++) @(posedge Clock);
    #1;
    chk("reach_wait", enter_count - e0, 2);
    push_pair(8'd5, 8'd10);
    push_pair(8'd6, 8'd9);
    repeat (3) @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("arst_procreset", ProcReset, 1);
    chk("arst_busy", Busy, 0);
    chk("arst_resvalid", ResValid, 0);
    chk("arst_resdata", ResData, 0);
    chk("arst_enter", Enter, 0);
    chk("arst_inready", InReady, 1);
    opq.delete();
    sbq.delete();
    repeat (2) @(posedge Clock);
    #1;
    Reset      = 1'b0;
    halt_block = 0;
    r0 = res_count;
    p0 = prst_count;
    repeat (60) @(posedge Clock);
    #1;
    chk("post_rst_busy", Busy, 0);
    chk("post_rst_no_result", res_count, r0);
    chk("post_rst_no_job", prst_count, p0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
